// File: rtl/tile_shuffle_ctrl.sv
// tile_shuffle_ctrl
//   Builds a pseudo-random permutation of tile indices 0..N_TILES-1 in a
//   small table. The table is first filled with the identity, then it gets a
//   Fisher-Yates pass that draws its random numbers from a 16-bit Galois LFSR.
//   The same seed always produces the same permutation.
//
// Ports
//   clk, rst_n     : clock; synchronous active-low reset
//   start          : 1-cycle request to build a new permutation (IDLE only)
//   seed_load/seed : load the LFSR in IDLE; a zero seed maps to SEED_RST.
//                    seed_load wins over start in the same cycle.
//   busy           : high while the table is being built (INIT/SHUFFLE)
//   done           : one-cycle pulse when the permutation is complete
//   perm_valid     : the table holds a completed permutation
//   rd_addr/rd_data: combinational table read; reads 0 while busy or when
//                    rd_addr is out of range
module tile_shuffle_ctrl #(
  parameter int          N_TILES  = 24,
  parameter int          IDX_W    = 5,
  parameter logic [15:0] SEED_RST = 16'hACE1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             seed_load,
  input  logic [15:0]      seed,
  output logic             busy,
  output logic             done,
  output logic             perm_valid,
  input  logic [IDX_W-1:0] rd_addr,
  output logic [IDX_W-1:0] rd_data
);

  typedef enum logic [1:0] {IDLE, INIT, SHUFFLE, DONE} state_t;

  // lfsr[7:0] * (i+1) must keep every product bit until the >>8.
  localparam int PW = 8 + IDX_W + 1;

  state_t           state;
  logic [IDX_W-1:0] i;
  logic [15:0]      lfsr;
  logic [IDX_W-1:0] perm [N_TILES];

  logic [PW-1:0]    prod;
  logic [IDX_W-1:0] j;
  logic [15:0]      lfsr_nx;

  assign lfsr_nx = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);

  // Scaling an 8-bit random value by (i+1) and dropping the low 8 bits
  // gives j in 0..i without a divider.
  assign prod = PW'(lfsr[7:0]) * (PW'(i) + PW'(1));
  assign j    = IDX_W'(prod >> 8);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      i          <= '0;
      lfsr       <= SEED_RST;
      busy       <= 1'b0;
      done       <= 1'b0;
      perm_valid <= 1'b0;
      for (int k = 0; k < N_TILES; k++) perm[k] <= IDX_W'(k);
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (seed_load) begin
            lfsr <= (seed == 16'h0000) ? SEED_RST : seed;
          end else if (start) begin
            state      <= INIT;
            i          <= '0;
            perm_valid <= 1'b0;
            busy       <= 1'b1;
          end
        end
        INIT: begin
          perm[i] <= i;
          if (i == IDX_W'(N_TILES - 1)) state <= SHUFFLE;  // i stays at the top slot
          else                          i     <= i + 1'b1;
        end
        SHUFFLE: begin
          // Both writes carry the same value when j == i, so no special case.
          perm[i] <= perm[j];
          perm[j] <= perm[i];
          lfsr    <= lfsr_nx;
          i       <= i - 1'b1;
          if (i == IDX_W'(1)) begin
            state <= DONE;
            busy  <= 1'b0;
          end
        end
        DONE: begin
          done       <= 1'b1;
          perm_valid <= 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    rd_data = '0;
    if (!busy && ({1'b0, rd_addr} < (IDX_W+1)'(N_TILES))) rd_data = perm[rd_addr];
  end

endmodule

// File: tb/tb_tile_shuffle_ctrl.sv
// Bench for tile_shuffle_ctrl: a reference model computes the permutation
// directly with a Fisher-Yates loop and tracks the run timeline as a cycle
// count from the start edge; one compare process checks all outputs at every
// negedge. Directed runs cover reproducibility, seed handling, ignored
// start/seed_load mid-run and reset abort.
module tb_tile_shuffle_ctrl;
  localparam int N = 24;
  localparam int W = 5;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         seed_load = 1'b0;
  logic [15:0]  seed = 16'h0000;
  logic [W-1:0] rd_addr = '0;
  logic         busy, done, perm_valid;
  logic [W-1:0] rd_data;

  tile_shuffle_ctrl #(.N_TILES(N), .IDX_W(W), .SEED_RST(16'hACE1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .seed_load(seed_load), .seed(seed),
    .busy(busy), .done(done), .perm_valid(perm_valid),
    .rd_addr(rd_addr), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;
  int busy_cnt = 0;
  int done_cnt = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return {1'b0, l[15:1]} ^ (l[0] ? 16'hB400 : 16'h0000);
  endfunction

  function automatic int pick_j(input logic [7:0] b, input int i);
    return (int'(b) * (i + 1)) / 256;
  endfunction

  // ---------------- reference model ----------------
  bit          armed = 1'b0;
  int          cnt = -1;          // edges since the accepted start, -1 = idle
  bit          m_valid;
  logic [15:0] m_lfsr;
  int          m_tab [N];

  always @(posedge clk) begin
    if (!rst_n) begin
      armed = 1'b1; cnt = -1; m_valid = 1'b0; m_lfsr = 16'hACE1;
      for (int k = 0; k < N; k++) m_tab[k] = k;
    end else if (armed) begin
      if (cnt >= 0 && cnt < 2*N) cnt++;
      else begin
        cnt = -1;
        if (seed_load) m_lfsr = (seed == 16'h0000) ? 16'hACE1 : seed;
        else if (start) begin
          cnt = 0; m_valid = 1'b0;
          for (int k = 0; k < N; k++) m_tab[k] = k;
          for (int ii = N-1; ii >= 1; ii--) begin
            int jj, t;
            jj = pick_j(m_lfsr[7:0], ii);
            t = m_tab[ii]; m_tab[ii] = m_tab[jj]; m_tab[jj] = t;
            m_lfsr = lfsr_step(m_lfsr);
          end
        end
      end
      if (cnt == 2*N) m_valid = 1'b1;
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (armed) begin
      bit eb;
      int ed;
      eb = (cnt >= 0) && (cnt <= 2*N-2);
      ed = (!eb && int'(rd_addr) < N) ? m_tab[rd_addr] : 0;
      chk("busy", int'(busy), int'(eb));
      chk("done", int'(done), int'(cnt == 2*N));
      chk("perm_valid", int'(perm_valid), int'(m_valid));
      chk("rd_data", int'(rd_data), ed);
      busy_cnt += int'(busy);
      done_cnt += int'(done);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic read_tab(output int tab [N]);
    for (int a = 0; a < N; a++) begin
      rd_addr = W'(a); #2; tab[a] = int'(rd_data); step();
    end
  endtask

  task automatic run(input logic [15:0] s, input bit use_seed, input int restart_at,
                     input int abort_at, output int tab [N]);
    if (use_seed) begin
      seed = s; seed_load = 1'b1; step(); seed_load = 1'b0;
    end
    busy_cnt = 0; done_cnt = 0;
    rst_n = 1'b1; start = 1'b1; step(); start = 1'b0;   // edge 0 of the run
    for (int c = 1; c <= 2*N + 4; c++) begin
      rd_addr   = W'(c % 32);
      start     = (c == restart_at);
      seed_load = (c == 12);
      seed      = 16'h5555;
      rst_n     = !(c == abort_at);
      step();
    end
    start = 1'b0; seed_load = 1'b0; rst_n = 1'b1;
    if (abort_at < 0) begin
      chk("done_pulses", done_cnt, 1);
      chk("busy_cycles", busy_cnt, 2*N - 1);
    end else begin
      chk("abort_no_done", done_cnt, 0);
    end
    read_tab(tab);
  endtask

  function automatic int unique_cnt(input int tab [N]);
    bit seen [N];
    int u = 0;
    foreach (seen[k]) seen[k] = 1'b0;
    foreach (tab[k]) if (tab[k] >= 0 && tab[k] < N && !seen[tab[k]]) begin
      seen[tab[k]] = 1'b1; u++;
    end
    return u;
  endfunction

  function automatic int diff_cnt(input int a [N], input int b [N]);
    int d = 0;
    for (int k = 0; k < N; k++) if (a[k] != b[k]) d++;
    return d;
  endfunction

  int t1 [N], t2 [N], t3 [N], t4 [N], t5 [N], t6 [N], t7 [N], t8 [N];

  initial begin
    // pin the model helpers with hand-computed values
    chk("lfsr_step_ace1", int'(lfsr_step(16'hACE1)), 32'hE270);
    chk("j_0x34_i23", pick_j(8'h34, 23), 4);
    chk("j_max_i23", pick_j(8'hFF, 23), 23);
    chk("j_zero_i5", pick_j(8'h00, 5), 0);

    rst_n = 1'b0; step(); step(); rst_n = 1'b1;

    // reset state: identity table, out-of-range reads 0
    for (int a = 0; a < 32; a++) begin
      rd_addr = W'(a); #2;
      chk("ident_rd", int'(rd_data), (a < N) ? a : 0);
      step();
    end
    chk("rst_busy", int'(busy), 0);
    chk("rst_valid", int'(perm_valid), 0);

    run(16'h1234, 1'b1, -1, -1, t1);
    chk("perm_1234_unique", unique_cnt(t1), N);
    chk("valid_after_run", int'(perm_valid), 1);

    rst_n = 1'b0; step(); rst_n = 1'b1; step();
    run(16'h1234, 1'b1, -1, -1, t2);
    chk("same_seed_same_tab", diff_cnt(t1, t2), 0);

    run(16'h4321, 1'b1, -1, -1, t3);
    chk("perm_4321_unique", unique_cnt(t3), N);
    chk("diff_seed_diff_tab", int'(diff_cnt(t1, t3) > 0), 1);

    run(16'h0000, 1'b1, 10, -1, t4);           // restart attempt at cycle 10
    run(16'hACE1, 1'b1, -1, -1, t5);
    chk("seed0_eq_ace1", diff_cnt(t4, t5), 0);
    chk("perm_ace1_unique", unique_cnt(t5), N);

    run(16'h1234, 1'b1, -1, 30, t6);            // reset at cycle 30
    for (int a = 0; a < N; a++) chk("abort_ident", t6[a], a);
    chk("abort_valid", int'(perm_valid), 0);

    // start in the first cycle rst_n is released; LFSR back at 16'hACE1
    rst_n = 1'b0; step();
    run(16'h0000, 1'b0, -1, -1, t7);
    chk("post_rst_start_eq_ace1", diff_cnt(t7, t5), 0);

    run(16'h1234, 1'b1, -1, -1, t8);
    chk("rerun_1234", diff_cnt(t8, t1), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
